johnson_code_checker: RTL and testbench

- Receive end of the 4-bit shift-register (Johnson) counter: samples the counter's `count` bus and decodes each code to a state index.
- Validates code legality and step-to-step sequencing.
- Tracks lock to the count sequence and accumulates a saturating error count.
- Sits beside the counter as its run-time monitor; the decoded index feeds downstream phase logic.

---
 rtl/johnson_pkg.sv | 21 ++
 rtl/johnson_decode.sv | 38 +++
 rtl/johnson_code_checker.sv | 157 +++++++++++++++
 tb/tb_johnson_code_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and sizing helpers for the Johnson counter monitor.
// Imported by the decoder and the checker top.
package johnson_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  function automatic int num_states(input int w);
    return 2 * w;
  endfunction

  function automatic int idx_w(input int w);
    return $clog2(2 * w);
  endfunction

  localparam int NUM_STATES = num_states(4);
  localparam int IDX_W      = idx_w(4);

endpackage

// File: rtl/johnson_decode.sv
// Combinational Johnson code decoder: legality check and state index.
// Usable by any consumer of the counter bus.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IW    = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IW-1:0]    index
);

  logic [WIDTH-1:0] w_v;
  logic [WIDTH-1:0] w_inc;
  int               w_pop;

  // Fold msb=1 codes onto the msb=0 form; legal iff ones are LSB-contiguous.
  always_comb begin
    w_v   = code[WIDTH-1] ? ~code : code;
    w_inc = w_v + WIDTH'(1);
    legal = ((w_v & w_inc) == '0);
  end

  // Index from popcount, mirrored for the falling half of the sequence.
  always_comb begin
    w_pop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      w_pop = w_pop + int'(code[i]);
    end
    if (code[WIDTH-1]) begin
      index = IW'(2 * WIDTH - w_pop);
    end else begin
      index = IW'(w_pop);
    end
  end

endmodule

// File: rtl/johnson_code_checker.sv
// Run-time monitor for a Johnson counter: decode, sequencing check,
// lock tracking and a saturating error counter.
module johnson_code_checker
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           code,
  input  logic                       err_clr,
  output logic [$clog2(2*WIDTH)-1:0] index,
  output logic                       index_valid,
  output logic                       locked,
  output logic                       illegal_code,
  output logic                       seq_err,
  output logic [ERR_W-1:0]           err_count
);

  localparam int NS = num_states(WIDTH);
  localparam int IW = $clog2(2 * WIDTH);
  localparam int CW = $clog2(LOCK_CNT + 1);

  logic          w_legal;
  logic [IW-1:0] w_idx;
  logic [IW-1:0] w_next_idx;
  logic          w_good;
  logic          w_bad;
  logic          w_ill;
  logic          w_err;
  logic          w_err_inc;
  state_t        w_state_nx;
  logic [CW-1:0] w_cnt_nx;

  state_t        r_state;
  logic [CW-1:0] r_good_cnt;
  logic [IW-1:0] r_prev_idx;
  logic          r_prev_ok;
  logic [IW-1:0] r_index;
  logic          r_iv;
  logic          r_ill;
  logic          r_seq;
  logic [ERR_W-1:0] r_err;

  johnson_decode #(
    .WIDTH (WIDTH),
    .IW    (IW)
  ) u_dec (
    .code  (code),
    .legal (w_legal),
    .index (w_idx)
  );

  // Classify the current sample against the last legal one.
  always_comb begin
    if (r_prev_idx == IW'(NS - 1)) begin
      w_next_idx = '0;
    end else begin
      w_next_idx = r_prev_idx + IW'(1);
    end
    w_good = in_valid & w_legal & r_prev_ok & (w_idx == w_next_idx);
    w_bad  = in_valid & w_legal & r_prev_ok & (w_idx != w_next_idx);
    w_ill  = in_valid & ~w_legal;
    w_err  = w_bad | w_ill;
  end

  // Lock FSM next state; errors only count against a held lock.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_good_cnt;
    w_err_inc  = 1'b0;
    unique case (r_state)
      HUNT: begin
        if (w_err) begin
          w_cnt_nx = '0;
        end else if (w_good) begin
          if (r_good_cnt == CW'(LOCK_CNT - 1)) begin
            w_state_nx = LOCKED;
            w_cnt_nx   = '0;
          end else begin
            w_cnt_nx = r_good_cnt + CW'(1);
          end
        end
      end
      LOCKED: begin
        if (w_err) begin
          w_state_nx = HUNT;
          w_cnt_nx   = '0;
          w_err_inc  = 1'b1;
        end
      end
      default: begin
        w_state_nx = HUNT;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= HUNT;
      r_good_cnt <= '0;
    end else begin
      r_state    <= w_state_nx;
      r_good_cnt <= w_cnt_nx;
    end
  end

  // Decoded index, history and one-cycle event pulses.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_prev_idx <= '0;
      r_prev_ok  <= 1'b0;
      r_index    <= '0;
      r_iv       <= 1'b0;
      r_ill      <= 1'b0;
      r_seq      <= 1'b0;
    end else begin
      r_ill <= w_ill;
      r_seq <= w_bad;
      if (in_valid) begin
        if (w_legal) begin
          r_index    <= w_idx;
          r_iv       <= 1'b1;
          r_prev_idx <= w_idx;
          r_prev_ok  <= 1'b1;
        end else begin
          r_iv      <= 1'b0;
          r_prev_ok <= 1'b0;
        end
      end
    end
  end

  // Saturating error counter; a clear still records a same-edge error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_err <= '0;
    end else if (err_clr) begin
      r_err <= ERR_W'(w_err_inc);
    end else if (w_err_inc && (r_err != '1)) begin
      r_err <= r_err + ERR_W'(1);
    end
  end

  assign index        = r_index;
  assign index_valid  = r_iv;
  assign locked       = (r_state == LOCKED);
  assign illegal_code = r_ill;
  assign seq_err      = r_seq;
  assign err_count    = r_err;

endmodule

// File: tb/tb_johnson_code_checker.sv
// Table-driven scoreboard bench for johnson_code_checker.
// A second instance with ERR_W=2 shares the stimulus to show saturation.
module tb_johnson_code_checker;

  typedef struct {
    logic       v;
    logic [3:0] c;
    logic       clr;
    logic [2:0] idx;
    logic       iv;
    logic       lk;
    logic       ill;
    logic       sq;
    logic [7:0] err;
    logic [1:0] err2;
  } vec_t;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       in_valid;
  logic [3:0] code;
  logic       err_clr;

  logic [2:0] index;
  logic       index_valid;
  logic       locked;
  logic       illegal_code;
  logic       seq_err;
  logic [7:0] err_count;

  logic [2:0] s_index;
  logic       s_index_valid;
  logic       s_locked;
  logic       s_illegal_code;
  logic       s_seq_err;
  logic [1:0] s_err_count;

  int n_vec = 0;
  int n_bad = 0;
  vec_t tbl[$];
  vec_t sb[$];
  int   sb_id[$];

  johnson_code_checker #(
    .WIDTH(4), .LOCK_CNT(3), .ERR_W(8)
  ) u_dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_valid     (in_valid),
    .code         (code),
    .err_clr      (err_clr),
    .index        (index),
    .index_valid  (index_valid),
    .locked       (locked),
    .illegal_code (illegal_code),
    .seq_err      (seq_err),
    .err_count    (err_count)
  );

  johnson_code_checker #(
    .WIDTH(4), .LOCK_CNT(3), .ERR_W(2)
  ) u_sat (
    .clk          (clk),
    .n_rst        (n_rst),
    .in_valid     (in_valid),
    .code         (code),
    .err_clr      (err_clr),
    .index        (s_index),
    .index_valid  (s_index_valid),
    .locked       (s_locked),
    .illegal_code (s_illegal_code),
    .seq_err      (s_seq_err),
    .err_count    (s_err_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic v, input logic [3:0] c, input logic clr,
    input logic [2:0] idx, input logic iv, input logic lk,
    input logic ill, input logic sq,
    input logic [7:0] err, input logic [1:0] err2);
    vec_t r;
    r.v = v; r.c = c; r.clr = clr;
    r.idx = idx; r.iv = iv; r.lk = lk;
    r.ill = ill; r.sq = sq;
    r.err = err; r.err2 = err2;
    return r;
  endfunction

  task automatic check(input string nm, input vec_t e);
    n_vec++;
    if (index !== e.idx || index_valid !== e.iv ||
        locked !== e.lk || illegal_code !== e.ill ||
        seq_err !== e.sq || err_count !== e.err ||
        s_err_count !== e.err2) begin
      n_bad++;
      $display("FAIL %s: got idx=%0d iv=%b lk=%b ill=%b seq=%b err=%0d err2=%0d want idx=%0d iv=%b lk=%b ill=%b seq=%b err=%0d err2=%0d",
        nm, index, index_valid, locked, illegal_code, seq_err,
        err_count, s_err_count, e.idx, e.iv, e.lk, e.ill, e.sq,
        e.err, e.err2);
    end
  endtask

  task automatic pop_check();
    vec_t e;
    int   id;
    if (sb.size() > 0) begin
      e  = sb.pop_front();
      id = sb_id.pop_front();
      check($sformatf("vec%0d", id), e);
    end
  endtask

  task automatic apply(input vec_t t, input int id);
    @(negedge clk);
    pop_check();
    in_valid = t.v;
    code     = t.c;
    err_clr  = t.clr;
    sb.push_back(t);
    sb_id.push_back(id);
  endtask

  task automatic drain();
    @(negedge clk);
    pop_check();
    in_valid = 1'b0;
    err_clr  = 1'b0;
  endtask

  initial begin
    vec_t z;
    z = mk(0, 4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);

    // clean run to lock
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 0, 3, 1, 1, 0, 0, 0, 0));
    // locked, through the wrap
    tbl.push_back(mk(1, 4'b1111, 0, 4, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1110, 0, 5, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1100, 0, 6, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 7, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 1, 0, 0, 0, 0));
    // ignored sample
    tbl.push_back(mk(0, 4'b0101, 0, 1, 1, 1, 0, 0, 0, 0));
    // illegal while locked, recover, relock
    tbl.push_back(mk(1, 4'b0101, 0, 1, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0111, 0, 3, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1111, 0, 4, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1110, 0, 5, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1100, 0, 6, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b1000, 0, 7, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 1, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 1, 1, 0, 0, 1, 1));
    // skip while locked, repeat in hunt
    tbl.push_back(mk(1, 4'b1111, 0, 4, 1, 0, 0, 1, 2, 2));
    tbl.push_back(mk(1, 4'b1111, 0, 4, 1, 0, 0, 1, 2, 2));
    tbl.push_back(mk(0, 4'b1111, 0, 4, 1, 0, 0, 0, 2, 2));
    // relock, then errors toward saturation
    tbl.push_back(mk(1, 4'b1110, 0, 5, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 4'b1100, 0, 6, 1, 0, 0, 0, 2, 2));
    tbl.push_back(mk(1, 4'b1000, 0, 7, 1, 1, 0, 0, 2, 2));
    tbl.push_back(mk(1, 4'b1010, 0, 7, 0, 0, 1, 0, 3, 3));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 1, 0, 0, 0, 3, 3));
    tbl.push_back(mk(1, 4'b0111, 0, 3, 1, 1, 0, 0, 3, 3));
    tbl.push_back(mk(1, 4'b0111, 0, 3, 1, 0, 0, 1, 4, 3));
    tbl.push_back(mk(1, 4'b1111, 0, 4, 1, 0, 0, 0, 4, 3));
    tbl.push_back(mk(1, 4'b1110, 0, 5, 1, 0, 0, 0, 4, 3));
    tbl.push_back(mk(1, 4'b1100, 0, 6, 1, 1, 0, 0, 4, 3));
    // clear with error, clear alone, illegal in hunt
    tbl.push_back(mk(1, 4'b1001, 1, 6, 0, 0, 1, 0, 1, 1));
    tbl.push_back(mk(0, 4'b1001, 1, 6, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0110, 0, 6, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 4'b0110, 0, 6, 0, 0, 0, 0, 0, 0));
    // relock, skip error, relock for the reset test
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b0111, 0, 3, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 4'b1000, 0, 7, 1, 0, 0, 1, 1, 1));
    tbl.push_back(mk(1, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0001, 0, 1, 1, 0, 0, 0, 1, 1));
    tbl.push_back(mk(1, 4'b0011, 0, 2, 1, 1, 0, 0, 1, 1));

    n_rst    = 1'b0;
    in_valid = 1'b0;
    code     = 4'b0000;
    err_clr  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_init", z);
    n_rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i], i);
    end
    drain();

    // async reset while locked with a nonzero error count
    #2 n_rst = 1'b0;
    #1 check("reset_async", z);
    repeat (2) @(negedge clk);
    check("reset_hold", z);
    n_rst = 1'b1;

    // first sample after reset: legal but no lock history
    apply(mk(1, 4'b0001, 0, 1, 1, 0, 0, 0, 0, 0), 100);
    apply(mk(1, 4'b0011, 0, 2, 1, 0, 0, 0, 0, 0), 101);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
